ibex_mem_arbiter: RTL

//  Parametrised N-port arbiter between Ibex OBI-style masters (instr, data, debug/DMA) and one single-port SRAM.

---
 rtl/ibex_mem_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/ibex_mem_arbiter.sv
// rtl/ibex_mem_arbiter.sv - N-port OBI arbiter onto one single-port SRAM with fixed-latency response routing
// Optional: define IBEX_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module ibex_mem_arbiter #(
    parameter int unsigned NumPorts   = 2,
    parameter int unsigned MemSize    = 8 * 1024,
    parameter logic [31:0] MemStart   = 32'h0,
    parameter int unsigned MemLatency = 1
) (
    input  logic                     clk_sys,
    input  logic                     rst_sys_n,
    input  logic [NumPorts-1:0]      req_i,
    input  logic [NumPorts-1:0]      we_i,
    input  logic [4*NumPorts-1:0]    be_i,
    input  logic [32*NumPorts-1:0]   addr_i,
    input  logic [32*NumPorts-1:0]   wdata_i,
    output logic [NumPorts-1:0]      gnt_o,
    output logic [NumPorts-1:0]      rvalid_o,
    output logic [NumPorts-1:0]      err_o,
    output logic [32*NumPorts-1:0]   rdata_o,
    output logic                     mem_req_o,
    output logic                     mem_we_o,
    output logic [3:0]               mem_be_o,
    output logic [31:0]              mem_addr_o,
    output logic [31:0]              mem_wdata_o,
    input  logic [31:0]              mem_rdata_i
);

    localparam int unsigned PortW   = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    localparam int unsigned Last    = MemLatency - 1;
    localparam logic [31:0] WinMask = ~(32'(MemSize) - 32'd1);

    logic [31:0] addr_a  [NumPorts];
    logic [31:0] wdata_a [NumPorts];
    logic [3:0]  be_a    [NumPorts];

    for (genvar p = 0; p < NumPorts; p++) begin : g_unpack
        assign addr_a[p]  = addr_i[32*p +: 32];
        assign wdata_a[p] = wdata_i[32*p +: 32];
        assign be_a[p]    = be_i[4*p +: 4];
    end

    logic             any_req;
    logic [PortW-1:0] win;

`ifdef IBEX_ARB_FIXED_PRIO_EN
    // Scan from the top so the lowest requesting index is the last to overwrite win.
    always_comb begin
        any_req = 1'b0;
        win     = '0;
        for (int i = int'(NumPorts) - 1; i >= 0; i--) begin
            if (req_i[PortW'(i)]) begin
                any_req = 1'b1;
                win     = PortW'(i);
            end
        end
    end
`else
    logic [PortW-1:0] ptr;
    logic [PortW:0]   cand;

    always_comb begin
        any_req = 1'b0;
        win     = '0;
        cand    = '0;
        for (int i = 0; i < int'(NumPorts); i++) begin
            cand = {1'b0, ptr} + (PortW+1)'(i);
            if (cand >= (PortW+1)'(NumPorts)) begin
                cand = cand - (PortW+1)'(NumPorts);
            end
            if (!any_req && req_i[cand[PortW-1:0]]) begin
                any_req = 1'b1;
                win     = cand[PortW-1:0];
            end
        end
    end

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            ptr <= '0;
        end else if (any_req) begin
            ptr <= (win == PortW'(NumPorts - 1)) ? '0 : win + 1'b1;
        end
    end
`endif

    logic granted;
    logic in_win;

    assign granted = any_req & rst_sys_n;
    assign in_win  = (addr_a[win] & WinMask) == MemStart;

    always_comb begin
        gnt_o = '0;
        if (granted) begin
            gnt_o[win] = 1'b1;
        end
    end

    // Idle or out-of-window cycles keep the RAM bus at zero.
    assign mem_req_o   = granted & in_win;
    assign mem_we_o    = mem_req_o & we_i[win];
    assign mem_be_o    = mem_req_o ? be_a[win]    : 4'h0;
    assign mem_addr_o  = mem_req_o ? addr_a[win]  : 32'h0;
    assign mem_wdata_o = mem_req_o ? wdata_a[win] : 32'h0;

    logic             pipe_valid [MemLatency];
    logic             pipe_err   [MemLatency];
    logic             pipe_rd    [MemLatency];
    logic [PortW-1:0] pipe_port  [MemLatency];

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            for (int i = 0; i < int'(MemLatency); i++) begin
                pipe_valid[i] <= 1'b0;
                pipe_err[i]   <= 1'b0;
                pipe_rd[i]    <= 1'b0;
                pipe_port[i]  <= '0;
            end
        end else begin
            pipe_valid[0] <= any_req;
            pipe_err[0]   <= !in_win;
            pipe_rd[0]    <= !we_i[win];
            pipe_port[0]  <= win;
            for (int i = 1; i < int'(MemLatency); i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_err[i]   <= pipe_err[i-1];
                pipe_rd[i]    <= pipe_rd[i-1];
                pipe_port[i]  <= pipe_port[i-1];
            end
        end
    end

    for (genvar p = 0; p < NumPorts; p++) begin : g_resp
        logic hit;
        assign hit                = pipe_valid[Last] && (pipe_port[Last] == PortW'(p));
        assign rvalid_o[p]        = hit;
        assign err_o[p]           = hit & pipe_err[Last];
        assign rdata_o[32*p +: 32] = (hit && pipe_rd[Last] && !pipe_err[Last]) ? mem_rdata_i : 32'h0;
    end

endmodule
